// File: rtl/stream_demux.sv
// Two-port stream demultiplexer with a one-entry holding register per output port.
// Optional per-port delivery counters are built when STREAM_DEMUX_CNT_EN is defined.
module stream_demux #(
  parameter int SIZE = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            sel,
  output logic [SIZE-1:0] out_a,
  output logic            out_a_valid,
  input  logic            out_a_ready,
  output logic [SIZE-1:0] out_b,
  output logic            out_b_valid,
  input  logic            out_b_ready
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [7:0]      cnt_a,
  output logic [7:0]      cnt_b
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state_a_r;
  state_t          state_b_r;
  state_t          state_a_nxt_s;
  state_t          state_b_nxt_s;
  logic [SIZE-1:0] data_a_r;
  logic [SIZE-1:0] data_b_r;
  logic            acc_a_s;
  logic            acc_b_s;
  logic            dlv_a_s;
  logic            dlv_b_s;
  logic            ready_s;

  // Handshake decode; readiness looks only at the selected port, never at in_valid.
  always_comb begin
    dlv_a_s = (state_a_r == FULL) && out_a_ready;
    dlv_b_s = (state_b_r == FULL) && out_b_ready;
    if (sel) begin
      ready_s = (state_b_r == EMPTY) || out_b_ready;
    end else begin
      ready_s = (state_a_r == EMPTY) || out_a_ready;
    end
    acc_a_s = in_valid && ready_s && !sel;
    acc_b_s = in_valid && ready_s && sel;
  end

  // State registers for both port FSMs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_a_r <= EMPTY;
      state_b_r <= EMPTY;
    end else begin
      state_a_r <= state_a_nxt_s;
      state_b_r <= state_b_nxt_s;
    end
  end

  // Next-state logic; a simultaneous delivery and accept keeps the port FULL.
  always_comb begin
    state_a_nxt_s = state_a_r;
    state_b_nxt_s = state_b_r;
    case (state_a_r)
      EMPTY:   if (acc_a_s) state_a_nxt_s = FULL; else state_a_nxt_s = EMPTY;
      FULL:    if (dlv_a_s && !acc_a_s) state_a_nxt_s = EMPTY; else state_a_nxt_s = FULL;
      default: state_a_nxt_s = EMPTY;
    endcase
    case (state_b_r)
      EMPTY:   if (acc_b_s) state_b_nxt_s = FULL; else state_b_nxt_s = EMPTY;
      FULL:    if (dlv_b_s && !acc_b_s) state_b_nxt_s = EMPTY; else state_b_nxt_s = FULL;
      default: state_b_nxt_s = EMPTY;
    endcase
  end

  // Output decode straight from the state and data registers.
  always_comb begin
    in_ready    = ready_s;
    out_a_valid = (state_a_r == FULL);
    out_b_valid = (state_b_r == FULL);
    out_a       = data_a_r;
    out_b       = data_b_r;
  end

  // Holding registers keep the last loaded word while the port is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_a_r <= {SIZE{1'b0}};
      data_b_r <= {SIZE{1'b0}};
    end else begin
      if (acc_a_s) begin
        data_a_r <= in;
      end
      if (acc_b_s) begin
        data_b_r <= in;
      end
    end
  end

`ifdef STREAM_DEMUX_CNT_EN
  logic [7:0] cnt_a_r;
  logic [7:0] cnt_b_r;

  // Delivery counters wrap naturally at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_r <= 8'd0;
      cnt_b_r <= 8'd0;
    end else begin
      if (dlv_a_s) begin
        cnt_a_r <= cnt_a_r + 8'd1;
      end
      if (dlv_b_s) begin
        cnt_b_r <= cnt_b_r + 8'd1;
      end
    end
  end

  assign cnt_a = cnt_a_r;
  assign cnt_b = cnt_b_r;
`endif

endmodule
